mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences and shares the single-port unified memory between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. It accepts level-held requests from IF and from the MEM-stage `mem_read`/`mem_write` control signals, and grants the port to one requester at a time. It drives the memory transaction and stalls the losing or waiting stage. Data accesses have priority, with a bounded-streak rule so fetch cannot starve, and a kill input discards in-flight fetches after a taken branch.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; fetch returns the full word and IF selects its 32 bits
- `MAX_STREAK`, 4, consecutive data grants allowed while `if_req` is pending; range 1..15
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request, held until `if_valid` or `if_kill`
- `if_addr` in ADDR_W: fetch address
- `if_kill` in 1: one-cycle pulse; cancel the pending or in-flight fetch
- `if_rdata` out DATA_W: fetch data, meaningful only while `if_valid`=1
- `if_valid` out 1: fetch complete
- `dm_mem_read` in 1: MEM-stage load request, held until `dm_valid`
- `dm_mem_write` in 1: MEM-stage store request, held until `dm_valid`
- `dm_addr` in ADDR_W: data address
- `dm_wdata` in DATA_W: store data
- `dm_rdata` out DATA_W: load data, meaningful only while `dm_valid`=1
- `dm_valid` out 1: data access complete
- `mem_req` out 1: registered; memory transaction active
- `mem_we` out 1: registered; 1 = write
- `mem_addr` out ADDR_W: registered address
- `mem_wdata` out DATA_W: registered write data
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ready`
- `mem_ready` in 1: memory completes the current transaction this cycle
- `stall_if` out 1: IF must hold
- `stall_mem` out 1: MEM and upstream stages must hold

## Operation
- **FSM states.** The FSM has three states: IDLE, BUSY_D and BUSY_I.
- **Data request.** `dreq = dm_mem_read | dm_mem_write`.
- **IDLE arbitration.**
  - If `dreq`=1 and not (`if_req`=1 and `streak`=MAX_STREAK): go to BUSY_D. Capture `dm_addr`, `dm_wdata` and `mem_we = dm_mem_write`, and set `mem_req`=1.
  - Otherwise, if `if_req`=1 and `if_kill`=0: go to BUSY_I. Capture `if_addr`, set `mem_we`=0 and `mem_req`=1.
  - If neither condition holds, stay in IDLE.
- **Illegal read+write.** If `dm_mem_read` and `dm_mem_write` are both 1, the access is performed as a write.
- **Streak counter (4 bits).**
  - A BUSY_D grant while `if_req`=1 increments it, saturating at MAX_STREAK.
  - A BUSY_I grant, or any cycle in which `if_req`=0, clears it.
- **BUSY_D.**
  - Memory outputs are held stable.
  - On `mem_ready`=1: `dm_valid`=1 and `dm_rdata=mem_rdata` (combinational, same cycle), then go to IDLE at the next edge, with `mem_req` falling at that edge.
- **BUSY_I.**
  - If `if_kill` is pulsed in this state, or in the same cycle as the grant, the `kill_pend` flag is set.
  - On `mem_ready`=1: `if_valid = ~kill_pend & ~if_kill`, `if_rdata=mem_rdata`. Go to IDLE and clear `kill_pend`.
  - A killed fetch still completes on the memory side; its data is dropped.
- **Stalls (combinational).**
  - `stall_mem = dreq & ~dm_valid`.
  - `stall_if = (if_req & ~if_valid) | stall_mem`, so IF also holds whenever MEM is held.
- **Reset.** `rst`=1 puts the FSM in IDLE and sets `streak`=0 and `kill_pend`=0. `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` all become 0. `if_valid`, `dm_valid`, `stall_if` and `stall_mem` read 0 during reset. Reset mid-transaction abandons it; the memory model is reset by the same `rst`.
- **`mem_ready` while IDLE.** It is ignored and no valid output is produced.

## Timing
- **Grant.** A request seen in IDLE in cycle N gives `mem_req`=1 in cycle N+1.
- **Minimum latency.** The earliest `mem_ready` is in N+1, giving `*_valid` in N+1. Minimum latency is 1 cycle with back-to-back accesses every 2 cycles: one IDLE cycle between transactions is mandatory.
- **Request handshake.** Requesters see `*_valid` combinationally, advance at that edge and may present a new request in the following cycle, which is the IDLE cycle.
- **Memory outputs.** These change only on the edge of a grant or a return to IDLE, never mid-transaction.
- **`if_kill` while IDLE with `if_req`=1.** No grant to fetch that cycle. IF is expected to present the redirected address next cycle.

## Test plan
- **Single load.** Reset, then `dm_mem_read`=1, `dm_addr`=0x100, with memory ready after 1 cycle and returning 0xDEAD. Required: `mem_req` in N+1 with `mem_we`=0, `dm_valid`=1 with `dm_rdata`=0xDEAD in N+1, and `stall_mem` high only in N.
- **Store with variable latency.** `dm_mem_write`=1, `dm_wdata`=0x55, `mem_ready` after 3 cycles. Required: `mem_we`=1, `mem_addr` and `mem_wdata` stable for all 3 cycles, then a single-cycle `dm_valid`.
- **Collision.** `if_req` and `dreq` together in IDLE. Required: data is granted first, fetch is granted in the IDLE cycle after `dm_valid`, and `stall_if` stays high throughout.
- **Starvation bound.** `dreq` continuously high with `if_req`=1 and MAX_STREAK=4. Required: exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
- **Kill.** `if_kill` pulsed in BUSY_I, `mem_ready` 2 cycles later. Required: `if_valid` stays 0, the FSM returns to IDLE, and the next fetch returns data normally.
- **Reset mid-transaction.** Assert `rst` during BUSY_D. Required: at the next edge `mem_req`=0, FSM is IDLE, and every output is 0. A late `mem_ready` after reset produces no valid output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data access.
// Data wins in IDLE unless a fetch has waited MAX_STREAK consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_mem_read_i,
    input  logic              dm_mem_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    // state  | meaning
    // IDLE   | port free, arbitrate this cycle
    // BUSY_D | data load/store in flight
    // BUSY_I | instruction fetch in flight (possibly killed)
    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

    state_t            state_q, state_d;
    logic [3:0]        streak_q, streak_d;
    logic              kill_pend_q, kill_pend_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              dreq;
    logic              grant_dat;
    logic              grant_fet;

    assign dreq = dm_mem_read_i | dm_mem_write_i;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        kill_pend_d = kill_pend_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_dat   = 1'b0;
        grant_fet   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq && !(if_req_i && (streak_q == MAX_S))) begin
                    grant_dat   = 1'b1;
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_mem_write_i;  // read+write together resolves to a write
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (if_req_i && !if_kill_i) begin
                    grant_fet  = 1'b1;
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                end
            end
            BUSY_D: begin
                if (mem_ready_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            BUSY_I: begin
                if (if_kill_i) kill_pend_d = 1'b1;
                // a killed fetch still runs to completion so the memory sees a clean handshake
                if (mem_ready_i) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    kill_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req_i) begin
            streak_d = '0;
        end else if (grant_dat) begin
            streak_d = (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
        end else if (grant_fet) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            kill_pend_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            kill_pend_q <= kill_pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    assign dm_rdata_o  = mem_rdata_i;
    assign if_rdata_o  = mem_rdata_i;
    assign dm_valid_o  = ~rst_i & (state_q == BUSY_D) & mem_ready_i;
    assign if_valid_o  = ~rst_i & (state_q == BUSY_I) & mem_ready_i & ~kill_pend_q & ~if_kill_i;
    assign stall_mem_o = ~rst_i & dreq & ~dm_valid_o;
    assign stall_if_o  = ~rst_i & ((if_req_i & ~if_valid_o) | stall_mem_o);

endmodule
